// File: rtl/muldiv_hilo_pkg.sv
// Shared definitions for the multiply/divide HI/LO unit: opcode codes,
// state encodings, iteration count and opcode classification helpers.
package muldiv_hilo_pkg;

  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MTLO  = 6'h13;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1a;
  localparam logic [5:0] OP_DIVU  = 6'h1b;

  // One radix-2 step per operand bit.
  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } md_mode_e;

  function automatic logic is_iter_op(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [5:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_hilo_if.sv
// Request/response bundle between the EX stage (master) and the
// multiply/divide HI/LO unit (slave).
interface muldiv_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, opa, opb,
    input  hi, lo, busy, stall, done, div_zero
  );

  modport slave (
    input  start, op, opa, opb,
    output hi, lo, busy, stall, done, div_zero
  );
endinterface

// File: rtl/muldiv_hilo_step.sv
// Single radix-2 iteration of the unsigned magnitude datapath.
// Multiply: accumulator = {partial product high, remaining multiplier bits};
//   add the multiplicand when the current multiplier bit is set, shift right.
// Divide (restoring): accumulator = {partial remainder, dividend/quotient bits};
//   shift left, trial-subtract the divisor, keep the difference if no borrow.
module muldiv_hilo_step
  import muldiv_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_mode_e           mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;

  // Next accumulator for the selected operation.
  always_comb begin
    sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff      = rem_shift - {1'b0, opnd};
    acc_next  = acc;
    if (mode == MODE_MUL) begin
      if (acc[0]) begin
        acc_next = {sum, acc[WIDTH-1:1]};
      end else begin
        acc_next = {1'b0, acc[2*WIDTH-1:1]};
      end
    end else if (!diff[WIDTH]) begin
      acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Iterative ops run on operand magnitudes for MD_ITER steps, then a FIX cycle
// applies sign correction and writes HI/LO. mthi/mtlo complete in one edge.
module muldiv_hilo
  import muldiv_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_hilo_if.slave bus
);

  localparam logic [4:0] CNT_LAST = 5'(MD_ITER - 1);

  // Absolute value for signed ops; the most negative value maps onto itself,
  // which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    logic signed [WIDTH-1:0] n;
    n = -v;
    return (is_signed && (v < 0)) ? $unsigned(n) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v,
                                                       input logic neg);
    return neg ? -v : v;
  endfunction

  md_state_e          state, state_nxt;
  logic [4:0]         cnt;
  md_mode_e           mode_r;
  logic               neg_res_r;
  logic               neg_rem_r;
  logic               dz_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   opnd_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               busy;
  logic               done;
  logic               stall;
  logic               idle_like;
  logic               acc_iter;
  logic               acc_mthi;
  logic               acc_mtlo;
  logic               op_signed;
  logic               op_div;
  logic signed [WIDTH-1:0] opa_s;
  logic signed [WIDTH-1:0] opb_s;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign opa_s = $signed(bus.opa);
  assign opb_s = $signed(bus.opb);

  // Request decode: new requests are only accepted when not iterating.
  always_comb begin
    idle_like = (state == MD_IDLE) || (state == MD_DONE);
    op_signed = is_signed_op(bus.op);
    op_div    = is_div_op(bus.op);
    acc_iter  = idle_like && bus.start && is_iter_op(bus.op);
    acc_mthi  = idle_like && bus.start && (bus.op == OP_MTHI);
    acc_mtlo  = idle_like && bus.start && (bus.op == OP_MTLO);
    mag_a     = magnitude(opa_s, op_signed);
    mag_b     = magnitude(opb_s, op_signed);
  end

  muldiv_hilo_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .mode    (mode_r),
    .acc     (acc_r),
    .opnd    (opnd_r),
    .acc_next(acc_nxt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      MD_IDLE: begin
        state_nxt = acc_iter ? MD_CALC : MD_IDLE;
      end
      MD_CALC: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = MD_FIX;
        end
      end
      MD_FIX: begin
        busy      = 1'b1;
        state_nxt = MD_DONE;
      end
      MD_DONE: begin
        done      = 1'b1;
        state_nxt = acc_iter ? MD_CALC : MD_IDLE;
      end
      default: begin
        state_nxt = MD_IDLE;
      end
    endcase
    // EX must hold while iterating, and also in the cycle an iterative
    // request is being accepted.
    stall = busy || (bus.start && is_iter_op(bus.op));
  end

  // Iteration counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (acc_iter) begin
      cnt <= '0;
    end else if (state == MD_CALC) begin
      cnt <= cnt + 5'd1;
    end
  end

  // Divide-by-zero flag, reported alongside done.
  always_ff @(posedge clk) begin
    if (rst) begin
      dz_r <= 1'b0;
    end else if (acc_iter) begin
      dz_r <= op_div && (bus.opb == '0);
    end
  end

  // Operand latch and iteration datapath. The accumulator upper half is
  // cleared; the lower half holds the bits consumed by the iterations
  // (multiplier for multiply, dividend for divide).
  always_ff @(posedge clk) begin
    if (acc_iter) begin
      neg_res_r <= op_signed && (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
      if (op_div) begin
        mode_r    <= MODE_DIV;
        acc_r     <= {{WIDTH{1'b0}}, mag_a};
        opnd_r    <= mag_b;
        neg_rem_r <= op_signed && bus.opa[WIDTH-1];
      end else begin
        mode_r    <= MODE_MUL;
        acc_r     <= {{WIDTH{1'b0}}, mag_b};
        opnd_r    <= mag_a;
        neg_rem_r <= 1'b0;
      end
    end else if (state == MD_CALC) begin
      acc_r <= acc_nxt;
    end
  end

  // Sign correction of the magnitude result. A zero divisor leaves the
  // remainder equal to the dividend magnitude, so restoring the dividend
  // sign yields the original opa; the quotient is forced to all ones.
  always_comb begin
    prod_fix = cond_neg_wide(acc_r, neg_res_r);
    rem_fix  = cond_neg(acc_r[2*WIDTH-1:WIDTH], neg_rem_r);
    quo_fix  = dz_r ? '1 : cond_neg(acc_r[WIDTH-1:0], neg_res_r);
  end

  // Architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (acc_mthi) begin
      hi_r <= bus.opa;
    end else if (acc_mtlo) begin
      lo_r <= bus.opa;
    end else if (state == MD_FIX) begin
      if (mode_r == MODE_MUL) begin
        hi_r <= prod_fix[2*WIDTH-1:WIDTH];
        lo_r <= prod_fix[WIDTH-1:0];
      end else begin
        hi_r <= rem_fix;
        lo_r <= quo_fix;
      end
    end
  end

  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.busy     = busy;
  assign bus.stall    = stall;
  assign bus.done     = done;
  assign bus.div_zero = done && dz_r;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: iterative requests push their expected
// HI/LO/div_zero and issue cycle; a negedge monitor pops and compares on done.
module tb_muldiv_hilo;
  import muldiv_hilo_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic [31:0] issue;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_n;

  muldiv_hilo_if #(.WIDTH(32)) bus ();

  muldiv_hilo #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  // Latency: issued at negedge with N edges elapsed, accepted at edge N+1,
  // HI/LO written at edge N+34, done visible at the following negedge.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, want done=0");
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        check({mon_n, "_hi"}, bus.hi, mon_e.hi);
        check({mon_n, "_lo"}, bus.lo, mon_e.lo);
        check({mon_n, "_dz"}, 32'(bus.div_zero), 32'(mon_e.dz));
        check({mon_n, "_lat"}, 32'(cyc) - mon_e.issue, 32'd34);
      end
    end
  end

  // Called at a negedge; request is accepted at the next rising edge.
  task automatic issue_iter(input string name, input logic [5:0] opc,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo,
                            input logic edz);
    exp_t e;
    e.hi    = ehi;
    e.lo    = elo;
    e.dz    = edz;
    e.issue = 32'(cyc);
    exp_q.push_back(e);
    name_q.push_back(name);
    bus.start = 1'b1;
    bus.op    = opc;
    bus.opa   = a;
    bus.opb   = b;
    #1 check({name, "_stall"}, 32'(bus.stall), 32'd1);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Returns at the negedge where done is seen; counts busy cycles before it.
  task automatic wait_done(input string name, output int busy_n);
    bit seen;
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else if (bus.busy) busy_n++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got done=0 after 100 cycles, want done=1", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bn;
    int dn;
    bus.start = 1'b0;
    bus.op    = 6'h00;
    bus.opa   = 32'h0;
    bus.opb   = 32'h0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_dz", 32'(bus.div_zero), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);

    // Unsigned max multiply, timing of busy and done.
    issue_iter("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    wait_done("multu_max", bn);
    check("multu_busy_cycles", 32'(bn), 32'd33);
    @(negedge clk);
    check("multu_done_width", 32'(bus.done), 32'd0);

    // Signed multiplies; the second one issued back-to-back from DONE.
    issue_iter("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    wait_done("mult_neg", bn);
    issue_iter("mult_min", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    wait_done("mult_min", bn);

    // Divides, chained from DONE.
    issue_iter("div_neg_dvd", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    wait_done("div_neg_dvd", bn);
    issue_iter("div_neg_dvs", OP_DIV, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    wait_done("div_neg_dvs", bn);
    issue_iter("divu_7_2", OP_DIVU, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0);
    wait_done("divu_7_2", bn);
    issue_iter("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    wait_done("div_ovf", bn);
    issue_iter("divu_zero", OP_DIVU, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1);
    wait_done("divu_zero", bn);
    @(negedge clk);

    // mthi while idle: single edge, no stall.
    bus.start = 1'b1;
    bus.op    = OP_MTHI;
    bus.opa   = 32'h00001234;
    #1;
    check("mthi_stall", 32'(bus.stall), 32'd0);
    check("mthi_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("mthi_hi", bus.hi, 32'h00001234);
    check("mthi_lo_kept", bus.lo, 32'hFFFFFFFF);
    @(negedge clk);

    // Unrecognised opcode leaves HI/LO alone.
    bus.start = 1'b1;
    bus.op    = 6'h20;
    bus.opa   = 32'hA5A5A5A5;
    #1 check("badop_stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("badop_hi", bus.hi, 32'h00001234);
    check("badop_lo", bus.lo, 32'hFFFFFFFF);
    @(negedge clk);

    // mtlo presented during CALC is ignored and stalled.
    issue_iter("multu_mtlo", OP_MULTU, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, 1'b0);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MTLO;
    bus.opa   = 32'hDEADBEEF;
    #1 check("mtlo_calc_stall", 32'(bus.stall), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("multu_mtlo", bn);
    check("mtlo_ignored_lo", bus.lo, 32'h0000000C);
    @(negedge clk);

    // Reset in the middle of a multiply aborts it without a HI/LO write.
    issue_iter("mult_abort", OP_MULT, 32'h00000007, 32'h00000009, 32'h00000000, 32'h0000003F, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(exp_q.pop_back());
    void'(name_q.pop_back());
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_hi", bus.hi, 32'h0);
    check("abort_lo", bus.lo, 32'h0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);

    // Fresh divide after the abort.
    issue_iter("divu_after", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    wait_done("divu_after", bn);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
